// File: rtl/note_tone_gen.sv
// -----------------------------------------------------------------------------
// note_tone_gen
//
// Square-wave tone generator behind the PS/2 scan-code-to-note decoder.
// FinalNote (a half-period in CLK cycles, 0 = silence) arrives from another
// clock domain. It is synchronised into CLK and only accepted once it has held
// the same value for STABLE_CYCLES samples. The accepted half-period drives a
// glitch-free square wave. Pitch changes only take effect on a wave edge, and
// a key release plays a fixed sustain tail before the speaker falls silent.
//
// Ports
//   CLK          system clock, all logic on the rising edge
//   RST          synchronous, active-high reset
//   FinalNote    requested half-period, asynchronous to CLK
//   speaker      square-wave output
//   note_active  high while a tone is playing or sustaining
//   sustaining   high only during the release tail
//   cur_note     half-period currently being generated, 0 when idle
// -----------------------------------------------------------------------------
module note_tone_gen #(
    parameter int unsigned WIDTH          = 26,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned SUSTAIN_CYCLES = 5_000_000,
    parameter int unsigned MIN_HALF       = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] FinalNote,
    output logic             speaker,
    output logic             note_active,
    output logic             sustaining,
    output logic [WIDTH-1:0] cur_note
);

    localparam int unsigned      STAB_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MIN_HALF_W  = WIDTH'(MIN_HALF);
    localparam logic [31:0]      SUS_LAST    = (SUSTAIN_CYCLES == 0) ? 32'd0 : 32'(SUSTAIN_CYCLES - 1);
    localparam bit               HAS_SUSTAIN = (SUSTAIN_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SUSTAIN
    } state_e;

    // Synchroniser and stability filter
    logic [WIDTH-1:0]  s1_q, s2_q, cand_q, note_q;
    logic [STAB_W-1:0] stab_cnt_q;

    // Tone FSM
    state_e            state_q;
    logic [WIDTH-1:0]  cnt_q, cur_note_q;
    logic [31:0]       sus_cnt_q;
    logic              speaker_q, active_q, sustain_q;

    logic              valid;
    logic              toggle;

    // Values below MIN_HALF would drive the speaker too fast; treat as silence.
    assign valid  = (note_q >= MIN_HALF_W);
    // Last cycle of the current half-period. cur_note is never below 1 while
    // a tone runs, so the subtraction cannot wrap in PLAY or SUSTAIN.
    assign toggle = (cnt_q == cur_note_q - WIDTH'(1));

    // A multi-bit word crossing domains can be sampled mid-transition; the
    // stability count rejects such torn samples as well as short glitches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q       <= '0;
            s2_q       <= '0;
            cand_q     <= '0;
            stab_cnt_q <= '0;
            note_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here make s2 take the old s1,
            // giving a real two-flop chain; blocking would collapse it to one.
            s1_q <= FinalNote;
            s2_q <= s1_q;
            if (s2_q != cand_q) begin
                cand_q     <= s2_q;
                stab_cnt_q <= '0;
            end else if (stab_cnt_q != STAB_LAST) begin
                stab_cnt_q <= stab_cnt_q + STAB_W'(1);
            end
            if (stab_cnt_q == STAB_LAST) begin
                note_q <= cand_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sus_cnt_q  <= '0;
            speaker_q  <= 1'b0;
            cur_note_q <= '0;
            active_q   <= 1'b0;
            sustain_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    speaker_q <= 1'b0;
                    if (valid) begin
                        // Every tone starts on a rising edge.
                        state_q    <= PLAY;
                        cur_note_q <= note_q;
                        speaker_q  <= 1'b1;
                        active_q   <= 1'b1;
                    end
                end

                PLAY: begin
                    if (toggle) begin
                        speaker_q <= ~speaker_q;
                        cnt_q     <= '0;
                        // New pitch only at an edge so no half is truncated.
                        if (valid) begin
                            cur_note_q <= note_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                    if (!valid) begin
                        if (HAS_SUSTAIN) begin
                            state_q   <= SUSTAIN;
                            sus_cnt_q <= '0;
                            sustain_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            speaker_q  <= 1'b0;
                            cnt_q      <= '0;
                            cur_note_q <= '0;
                            active_q   <= 1'b0;
                        end
                    end
                end

                SUSTAIN: begin
                    // Tail keeps the held pitch; a new note resumes PLAY
                    // without resetting phase and loads at the next edge.
                    if (toggle) begin
                        speaker_q <= ~speaker_q;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                    sus_cnt_q <= sus_cnt_q + 32'd1;
                    if (valid) begin
                        state_q   <= PLAY;
                        sustain_q <= 1'b0;
                    end else if (sus_cnt_q == SUS_LAST) begin
                        // Expiry overrides a coincident toggle.
                        state_q    <= IDLE;
                        speaker_q  <= 1'b0;
                        cnt_q      <= '0;
                        cur_note_q <= '0;
                        active_q   <= 1'b0;
                        sustain_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    speaker_q  <= 1'b0;
                    cnt_q      <= '0;
                    cur_note_q <= '0;
                    active_q   <= 1'b0;
                    sustain_q  <= 1'b0;
                end
            endcase
        end
    end

    assign speaker     = speaker_q;
    assign note_active = active_q;
    assign sustaining  = sustain_q;
    assign cur_note    = cur_note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_note_tone_gen
//
// Bench for note_tone_gen with STABLE_CYCLES=4, SUSTAIN_CYCLES=20, MIN_HALF=2.
// A reference model tracks the expected outputs every cycle. It accepts a
// note when the input value seen three edges ago has been seen on four
// consecutive edges, and times the wave and the sustain tail from the edge
// numbers at which each half-period and each release began.
// -----------------------------------------------------------------------------
module tb_note_tone_gen;

    localparam int W    = 26;
    localparam int STAB = 4;
    localparam int SUS  = 20;
    localparam int MINH = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] FinalNote = '0;
    logic         speaker, note_active, sustaining;
    logic [W-1:0] cur_note;

    note_tone_gen #(
        .WIDTH         (W),
        .STABLE_CYCLES (STAB),
        .SUSTAIN_CYCLES(SUS),
        .MIN_HALF      (MINH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FinalNote  (FinalNote),
        .speaker    (speaker),
        .note_active(note_active),
        .sustaining (sustaining),
        .cur_note   (cur_note)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic spk, input logic act,
                                         input logic sus, input logic [W-1:0] cur);
        return {35'b0, spk, act, sus, cur};
    endfunction

    // ---------------- reference model ----------------
    int unsigned  n;          // edge index
    bit           m_on, m_sus, m_spk;
    logic [W-1:0] m_cur, m_noteq;
    int unsigned  m_last;     // edge at which the current half began
    int unsigned  m_rel;      // edge at which the release tail began
    logic [W-1:0] hist[$];    // hist[0] = most recent sampled input

    task automatic model_edge(input logic [W-1:0] fn, input logic rst);
        bit valid, tog, same;
        if (rst) begin
            m_on = 0; m_sus = 0; m_spk = 0; m_cur = '0; m_noteq = '0;
            hist = {};
            for (int i = 0; i < STAB + 2; i++) hist.push_back('0);
        end else begin
            valid = (int'(m_noteq) >= MINH);
            tog   = m_on && ((n - m_last) == 32'(m_cur));
            if (!m_on) begin
                if (valid) begin
                    m_on = 1; m_spk = 1; m_cur = m_noteq; m_last = n;
                end
            end else if (!m_sus) begin
                if (tog) begin
                    m_spk = !m_spk; m_last = n;
                    if (valid) m_cur = m_noteq;
                end
                if (!valid) begin
                    m_sus = 1; m_rel = n;
                end
            end else begin
                if (!valid && (n - m_rel) == SUS) begin
                    m_on = 0; m_sus = 0; m_spk = 0; m_cur = '0;
                end else begin
                    if (tog) begin
                        m_spk = !m_spk; m_last = n;
                    end
                    if (valid) m_sus = 0;
                end
            end
            // Acceptance: value sampled 3 edges ago, held for STAB samples.
            same = 1;
            for (int i = 3; i < STAB + 2; i++) if (hist[i] != hist[2]) same = 0;
            if (same) m_noteq = hist[2];
            hist.push_front(fn);
            void'(hist.pop_back());
        end
        n++;
    endtask

    // One clock: inputs are sampled at the edge, outputs checked 1 ns later.
    task automatic tick();
        logic [W-1:0] fn;
        logic         r;
        fn = FinalNote;
        r  = RST;
        @(posedge CLK);
        #1;
        model_edge(fn, r);
        check("model", pack(speaker, note_active, sustaining, cur_note),
              pack(m_spk, m_on, m_sus, m_cur));
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        FinalNote = '0;
        repeat (cycles) tick();
        RST = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] fn;
        int           ticks;
        logic         spk;
        logic         act;
        logic         sus;
        logic [W-1:0] cur;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n = 0;

        // Edge numbers in comments count from the first edge after reset
        // release at which FinalNote=5 is applied.
        //                fn  ticks spk act sus cur
        vecs.push_back('{5,  7, 0, 0, 0, 0});   // e7 note_q just accepted
        vecs.push_back('{5,  1, 1, 1, 0, 5});   // e8 tone starts high
        vecs.push_back('{5,  4, 1, 1, 0, 5});   // e12 still first half
        vecs.push_back('{5,  1, 0, 1, 0, 5});   // e13 first toggle
        vecs.push_back('{5,  5, 1, 1, 0, 5});   // e18
        vecs.push_back('{5,  1, 1, 1, 0, 5});   // e19
        vecs.push_back('{8,  3, 1, 1, 0, 5});   // e22 change to 8 mid-half
        vecs.push_back('{8,  1, 0, 1, 0, 5});   // e23 half completes at 5
        vecs.push_back('{8,  4, 0, 1, 0, 5});   // e27
        vecs.push_back('{8,  1, 1, 1, 0, 8});   // e28 new pitch at edge
        vecs.push_back('{8,  7, 1, 1, 0, 8});   // e35
        vecs.push_back('{8,  1, 0, 1, 0, 8});   // e36 half of 8
        vecs.push_back('{8,  8, 1, 1, 0, 8});   // e44
        vecs.push_back('{0,  6, 1, 1, 0, 8});   // e50 release pending
        vecs.push_back('{0,  1, 1, 1, 0, 8});   // e51 note_q now 0
        vecs.push_back('{0,  1, 0, 1, 1, 8});   // e52 toggle + enter sustain
        vecs.push_back('{0,  8, 1, 1, 1, 8});   // e60 toggling in tail
        vecs.push_back('{0, 11, 0, 1, 1, 8});   // e71 last tail cycle
        vecs.push_back('{0,  1, 0, 0, 0, 0});   // e72 tail expired
        vecs.push_back('{0, 10, 0, 0, 0, 0});   // e82 idle
        vecs.push_back('{5,  8, 1, 1, 0, 5});   // e90 restart
        vecs.push_back('{5, 10, 1, 1, 0, 5});   // e100
        vecs.push_back('{0,  8, 0, 1, 1, 5});   // e108 in sustain
        vecs.push_back('{5,  7, 0, 1, 1, 5});   // e115 toggle in tail
        vecs.push_back('{5,  1, 0, 1, 0, 5});   // e116 back to PLAY
        vecs.push_back('{5,  4, 1, 1, 0, 5});   // e120 phase continuous
        vecs.push_back('{5,  5, 0, 1, 0, 5});   // e125

        // Reset holds everything at zero; silence stays silent.
        do_reset(3);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_zero", pack(speaker, note_active, sustaining, cur_note), 64'd0);
        end

        // Tone, pitch change, release and re-press.
        do_reset(3);
        for (int i = 0; i < vecs.size(); i++) begin
            FinalNote = vecs[i].fn;
            repeat (vecs[i].ticks) tick();
            check($sformatf("vec%0d", i),
                  pack(speaker, note_active, sustaining, cur_note),
                  pack(vecs[i].spk, vecs[i].act, vecs[i].sus, vecs[i].cur));
        end

        // A 3-cycle glitch never reaches the filter's acceptance point.
        do_reset(3);
        FinalNote = 9;
        repeat (3) tick();
        FinalNote = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("glitch", {62'b0, speaker, note_active}, 64'd0);
        end

        // Below MIN_HALF is silence.
        do_reset(3);
        FinalNote = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("below_min", {62'b0, speaker, note_active}, 64'd0);
        end

        // Reset mid-tone aborts with no tail; restart needs re-acceptance.
        do_reset(3);
        FinalNote = 5;
        repeat (20) tick();
        check("pre_abort", pack(speaker, note_active, sustaining, cur_note), pack(1, 1, 0, 5));
        RST = 1'b1;
        tick();
        check("rst_abort", pack(speaker, note_active, sustaining, cur_note), 64'd0);
        RST = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("restart_wait", pack(speaker, note_active, sustaining, cur_note), 64'd0);
        end
        tick();
        check("restart", pack(speaker, note_active, sustaining, cur_note), pack(1, 1, 0, 5));

        // Random notes, glitches, releases and occasional resets.
        begin
            int hold;
            hold = 0;
            for (int i = 0; i < 2500; i++) begin
                if (hold == 0) begin
                    case ($urandom_range(0, 5))
                        0:       FinalNote = 0;
                        1:       FinalNote = 1;
                        2:       FinalNote = 2;
                        3:       FinalNote = 3;
                        4:       FinalNote = 5;
                        default: FinalNote = W'($urandom_range(0, 12));
                    endcase
                    hold = $urandom_range(1, 40);
                end
                hold--;
                RST = ($urandom_range(0, 299) == 0);
                tick();
            end
            RST = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
